// File: rtl/mano_io_port.sv
// Mano-style I/O port: keyboard FIFO feeding INPR/FGI, and a one-deep printer output with an IDLE/SEND handshake FSM.
// Keyboard byte reaches INPR one edge after FIFO accept; kbd_ready drops when the FIFO is full, and the printer holds its byte until prn_ready.
module mano_io_port #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] kbd_data,
  input  logic       kbd_valid,
  output logic       kbd_ready,
  output logic [7:0] inpr,
  output logic       fgi,
  input  logic       inp_ack,
  input  logic [7:0] outr_in,
  input  logic       out_strobe,
  output logic       fgo,
  output logic [7:0] prn_data,
  output logic       prn_valid,
  input  logic       prn_ready,
  input  logic       ien,
  output logic       irq,
  output logic       ovr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    inpr_q, inpr_d;
  logic          fgi_q, fgi_d;
  state_t        state_q, state_d;
  logic [7:0]    prn_data_q, prn_data_d;
  logic          ovr_err_q, ovr_err_d;
  logic          push, pop;

  // Full is judged from registered count only, so a same-cycle pop never frees a slot early.
  assign kbd_ready = (count_q < CW'(DEPTH));
  assign push      = kbd_valid && kbd_ready;
  assign pop       = !fgi_q && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    inpr_d   = inpr_q;
    fgi_d    = fgi_q;
    if (push) begin
      mem_d[wr_ptr_q] = kbd_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      inpr_d   = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Refill only while fgi is already low, which guarantees a low cycle between characters.
    if (pop) begin
      fgi_d = 1'b1;
    end else if (fgi_q && inp_ack) begin
      fgi_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    prn_data_d = prn_data_q;
    ovr_err_d  = ovr_err_q;
    case (state_q)
      IDLE: begin
        if (out_strobe) begin
          prn_data_d = outr_in;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (out_strobe) begin
          ovr_err_d = 1'b1;
        end
        if (prn_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inpr_q     <= '0;
      fgi_q      <= 1'b0;
      state_q    <= IDLE;
      prn_data_q <= '0;
      ovr_err_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inpr_q     <= inpr_d;
      fgi_q      <= fgi_d;
      state_q    <= state_d;
      prn_data_q <= prn_data_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign inpr      = inpr_q;
  assign fgi       = fgi_q;
  assign fgo       = (state_q == IDLE);
  assign prn_valid = (state_q == SEND);
  assign prn_data  = prn_data_q;
  assign ovr_err   = ovr_err_q;
  assign irq       = ien & (fgi_q | fgo);

endmodule
